// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit holding the architectural HI/LO
// registers. Multiplies and divides run for a fixed latency on operands latched
// at the start edge; MTHI/MTLO write HI/LO directly in a single cycle.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [2:0]  mdOpE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    output logic        busyE,
    output logic [31:0] hiE,
    output logic [31:0] loE
);

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    state_t      state;
    logic [31:0] count;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [2:0]  opCode;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] divS;
    logic [31:0] divU;
    logic [31:0] quotS;
    logic [31:0] remS;
    logic [31:0] quotU;
    logic [31:0] remU;
    logic        divZero;
    logic        divOvf;
    logic [31:0] resHi;
    logic [31:0] resLo;
    logic        resWrite;

    // Result datapath driven only by the operands latched at the start edge.
    always_comb begin
        divZero = (opB == 32'd0);
        // Most-negative / -1 overflows the quotient; handle it explicitly.
        divOvf  = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
        // Substitute a harmless divisor so the dividers never see 0 or overflow.
        divS    = (divZero || divOvf) ? 32'd1 : opB;
        divU    = divZero ? 32'd1 : opB;

        prodS   = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
        prodU   = {32'd0, opA} * {32'd0, opB};
        quotS   = $signed(opA) / $signed(divS);
        remS    = $signed(opA) % $signed(divS);
        quotU   = opA / divU;
        remU    = opA % divU;

        resHi    = hiReg;
        resLo    = loReg;
        resWrite = 1'b0;
        unique case (opCode)
            OpMult: begin
                resHi    = prodS[63:32];
                resLo    = prodS[31:0];
                resWrite = 1'b1;
            end
            OpMultu: begin
                resHi    = prodU[63:32];
                resLo    = prodU[31:0];
                resWrite = 1'b1;
            end
            OpDiv: begin
                if (divOvf) begin
                    resHi = 32'd0;
                    resLo = 32'h8000_0000;
                end else begin
                    resHi = remS;
                    resLo = quotS;
                end
                resWrite = !divZero;
            end
            OpDivu: begin
                resHi    = remU;
                resLo    = quotU;
                resWrite = !divZero;
            end
            default: begin
                resWrite = 1'b0;
            end
        endcase
    end

    // Control FSM plus HI/LO and busy state; all outputs are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= StIdle;
            count   <= 32'd0;
            opA     <= 32'd0;
            opB     <= 32'd0;
            opCode  <= 3'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            busyReg <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (startE) begin
                        case (mdOpE)
                            OpMult, OpMultu: begin
                                opA     <= srcAE;
                                opB     <= srcBE;
                                opCode  <= mdOpE;
                                count   <= MULT_CYCLES;
                                busyReg <= 1'b1;
                                state   <= StRun;
                            end
                            OpDiv, OpDivu: begin
                                opA     <= srcAE;
                                opB     <= srcBE;
                                opCode  <= mdOpE;
                                count   <= DIV_CYCLES;
                                busyReg <= 1'b1;
                                state   <= StRun;
                            end
                            OpMthi: hiReg <= srcAE;
                            OpMtlo: loReg <= srcAE;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    // startE is deliberately ignored for the whole of RUN.
                    if (count <= 32'd1) begin
                        if (resWrite) begin
                            hiReg <= resHi;
                            loReg <= resLo;
                        end
                        count   <= 32'd0;
                        busyReg <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign busyE = busyReg;
    assign hiE   = hiReg;
    assign loE   = loReg;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default latencies (5 / 10).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        startE;
    logic [2:0]  mdOpE;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic        busyE;
    logic [31:0] hiE;
    logic [31:0] loE;

    int checks;
    int failures;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .startE(startE),
        .mdOpE (mdOpE),
        .srcAE (srcAE),
        .srcBE (srcBE),
        .busyE (busyE),
        .hiE   (hiE),
        .loE   (loE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op on the next rising edge, scramble the live operands, then
    // count negedges with busy high (bounded). Ends on the first idle negedge.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        @(negedge clk);
        startE = 1'b1;
        mdOpE  = op;
        srcAE  = a;
        srcBE  = b;
        @(negedge clk);
        startE = 1'b0;
        srcAE  = ~a;
        srcBE  = ~b;
        cycles = 0;
        while (busyE === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        startE = 1'b0;
        mdOpE  = 3'd0;
        srcAE  = 32'd0;
        srcBE  = 32'd0;
        #12;
        checks++;
        if (busyE !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h required 0/0/0", busyE, hiE, loE);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int cyc;
        runOp(3'd0, 32'hFFFF_FFFE, 32'd3, cyc);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL mult_busy_cycles got=%0d required=5", cyc);
        end
        checks++;
        if (hiE !== 32'hFFFF_FFFF || loE !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mult_signed hi=%h lo=%h required ffffffff/fffffffa", hiE, loE);
        end
        runOp(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        checks++;
        if (cyc !== 5 || hiE !== 32'h0000_0002 || loE !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL multu cyc=%0d hi=%h lo=%h required 5/00000002/fffffffa",
                     cyc, hiE, loE);
        end
    endtask

    task automatic test_div();
        int cyc;
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (cyc !== 10) begin
            failures++;
            $display("FAIL div_busy_cycles got=%0d required=10", cyc);
        end
        checks++;
        if (hiE !== 32'hFFFF_FFFF || loE !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_signed hi=%h lo=%h required ffffffff/fffffffd", hiE, loE);
        end
        runOp(3'd3, 32'd7, 32'd2, cyc);
        checks++;
        if (cyc !== 10 || hiE !== 32'd1 || loE !== 32'd3) begin
            failures++;
            $display("FAIL divu cyc=%0d hi=%h lo=%h required 10/1/3", cyc, hiE, loE);
        end
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++;
        if (hiE !== 32'd0 || loE !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_overflow hi=%h lo=%h required 0/80000000", hiE, loE);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        runOp(3'd4, 32'h11, 32'd0, cyc);
        checks++;
        if (cyc !== 0 || hiE !== 32'h11) begin
            failures++;
            $display("FAIL mthi cyc=%0d hi=%h required 0/11", cyc, hiE);
        end
        runOp(3'd5, 32'h22, 32'd0, cyc);
        checks++;
        if (cyc !== 0 || loE !== 32'h22 || hiE !== 32'h11) begin
            failures++;
            $display("FAIL mtlo cyc=%0d hi=%h lo=%h required 0/11/22", cyc, hiE, loE);
        end
        runOp(3'd2, 32'd5, 32'd0, cyc);
        checks++;
        if (cyc !== 10 || hiE !== 32'h11 || loE !== 32'h22) begin
            failures++;
            $display("FAIL div_by_zero cyc=%0d hi=%h lo=%h required 10/11/22", cyc, hiE, loE);
        end
        runOp(3'd3, 32'd9, 32'd0, cyc);
        checks++;
        if (cyc !== 10 || hiE !== 32'h11 || loE !== 32'h22) begin
            failures++;
            $display("FAIL divu_by_zero cyc=%0d hi=%h lo=%h required 10/11/22", cyc, hiE, loE);
        end
    endtask

    task automatic test_noop();
        int cyc;
        runOp(3'd6, 32'hDEAD_BEEF, 32'd1, cyc);
        runOp(3'd7, 32'hCAFE_F00D, 32'd1, cyc);
        checks++;
        if (cyc !== 0 || hiE !== 32'h11 || loE !== 32'h22) begin
            failures++;
            $display("FAIL noop_ops cyc=%0d hi=%h lo=%h required 0/11/22", cyc, hiE, loE);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Start MULT 6*7 at edge T0.
        @(negedge clk);
        startE = 1'b1; mdOpE = 3'd0; srcAE = 32'd6; srcBE = 32'd7;
        @(negedge clk);
        checks++;
        if (busyE !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_start busy=%b required 1", busyE);
        end
        // Second MULT with new operands during RUN.
        mdOpE = 3'd0; srcAE = 32'd100; srcBE = 32'd100;
        @(negedge clk);
        // MTLO held through the completing edge T0+5.
        mdOpE = 3'd5; srcAE = 32'hDEAD;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busyE !== 1'b1 || hiE !== 32'h11 || loE !== 32'h22) begin
            failures++;
            $display("FAIL b2b_hold busy=%b hi=%h lo=%h required 1/11/22", busyE, hiE, loE);
        end
        @(negedge clk);
        checks++;
        if (busyE !== 1'b0 || hiE !== 32'd0 || loE !== 32'd42) begin
            failures++;
            $display("FAIL b2b_first_result busy=%b hi=%h lo=%h required 0/0/2a",
                     busyE, hiE, loE);
        end
        // Start on the edge after completion is accepted.
        mdOpE = 3'd0; srcAE = 32'd3; srcBE = 32'd4;
        @(negedge clk);
        startE = 1'b0; srcAE = 32'd9; srcBE = 32'd9;
        checks++;
        if (busyE !== 1'b1 || loE !== 32'd42) begin
            failures++;
            $display("FAIL b2b_next_accept busy=%b lo=%h required 1/2a", busyE, loE);
        end
        cyc = 1;
        while (busyE === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== 6 || hiE !== 32'd0 || loE !== 32'd12) begin
            failures++;
            $display("FAIL b2b_second_result cyc=%0d hi=%h lo=%h required 6/0/c", cyc, hiE, loE);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        runOp(3'd4, 32'h55, 32'd0, cyc);
        @(negedge clk);
        startE = 1'b1; mdOpE = 3'd2; srcAE = 32'd100; srcBE = 32'd7;
        @(negedge clk);
        startE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busyE !== 1'b1 || hiE !== 32'h55) begin
            failures++;
            $display("FAIL reset_pre busy=%b hi=%h required 1/55", busyE, hiE);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busyE !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            failures++;
            $display("FAIL reset_async busy=%b hi=%h lo=%h required 0/0/0", busyE, hiE, loE);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (busyE !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_late_write busy=%b hi=%h lo=%h required 0/0/0",
                     busyE, hiE, loE);
        end
        runOp(3'd0, 32'd6, 32'd7, cyc);
        checks++;
        if (cyc !== 5 || hiE !== 32'd0 || loE !== 32'd42) begin
            failures++;
            $display("FAIL reset_fresh_mult cyc=%0d hi=%h lo=%h required 5/0/2a", cyc, hiE, loE);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_noop();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
